// File: rtl/fft_mc_ctrl.sv
// Multi-channel FFT controller: streams NCH raw frames through one FFT engine via a
// 2-entry skid buffer and collects the engine output into a channel-banked result RAM.
`timescale 1ns/1ps
module fft_mc_ctrl #(
    parameter int NCH  = 4,
    parameter int DW   = 14,
    parameter int NPTS = 1024,
    parameter int AW   = $clog2(NPTS),
    parameter int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic               raw_ready,
    output logic               raw_rdreq,
    output logic [CW-1:0]      raw_ch,
    output logic [AW-1:0]      raw_addr,
    input  logic [DW-1:0]      raw_data,
    output logic               sink_valid,
    output logic               sink_sop,
    output logic               sink_eop,
    output logic [DW-1:0]      sink_real,
    input  logic               sink_ready,
    input  logic               source_valid,
    input  logic               source_sop,
    input  logic               source_eop,
    input  logic [DW-1:0]      source_real,
    input  logic [DW-1:0]      source_imag,
    output logic               res_wren,
    output logic [CW+AW-1:0]   res_addr,
    output logic [2*DW-1:0]    res_data,
    output logic               busy,
    output logic               done,
    output logic               err
);
    typedef enum logic [2:0] {IDLE, ARM, FEED, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NPTS - 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(NCH - 1);
    localparam int            SW       = DW + 2;

    state_t              state_q, state_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d, fin_q, fin_d;
    logic [CW-1:0]       fch_q, fch_d, och_q, och_d;
    logic [AW-1:0]       fidx_q, fidx_d, oidx_q, oidx_d;
    logic                fdone_q, fdone_d;
    logic                pend_q, pend_d, pend_sop_q, pend_sop_d, pend_eop_q, pend_eop_d;
    logic [1:0]          occ_q, occ_d;
    logic [SW-1:0]       s0_q, s0_d, s1_q, s1_d;
    logic                res_wren_q, res_wren_d;
    logic [CW+AW-1:0]    res_addr_q, res_addr_d;
    logic [2*DW-1:0]     res_data_q, res_data_d;

    logic                pop_s, rdreq_s, col_s;
    logic [SW-1:0]       in_s;
    logic [AW-1:0]       idx_eff_s;

    // A read is only issued when the buffer plus reads in flight leave room for its data.
    assign pop_s     = (occ_q != 2'd0) && sink_ready;
    assign rdreq_s   = (state_q == FEED) && !fdone_q &&
                       (({1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop_s}) < 3'd2);
    assign in_s      = {raw_data, pend_sop_q, pend_eop_q};
    assign col_s     = ((state_q == FEED) || (state_q == DRAIN)) && source_valid;
    assign idx_eff_s = source_sop ? AW'(0) : oidx_q;

    // Skid buffer: s0 is the head presented to the sink, s1 holds the overflow beat.
    always_comb begin
        occ_d = occ_q + {1'b0, pend_q} - {1'b0, pop_s};
        if (pop_s && (occ_q == 2'd2)) begin
            s0_d = s1_q;
        end else if (pend_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop_s))) begin
            s0_d = in_s;
        end else begin
            s0_d = s0_q;
        end
        if (pend_q && (occ_d == 2'd2)) begin
            s1_d = in_s;
        end else begin
            s1_d = s1_q;
        end
    end

    // Fetch counter, result collection and frame sequencing.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        fin_d      = fin_q;
        fch_d      = fch_q;
        fidx_d     = fidx_q;
        fdone_d    = fdone_q;
        och_d      = och_q;
        oidx_d     = oidx_q;
        pend_d     = rdreq_s;
        pend_sop_d = (fidx_q == AW'(0));
        pend_eop_d = (fidx_q == LAST_IDX);
        res_wren_d = col_s;
        res_addr_d = res_addr_q;
        res_data_d = res_data_q;

        if (rdreq_s) begin
            if (fidx_q == LAST_IDX) begin
                fidx_d = AW'(0);
                if (fch_q == LAST_CH) begin
                    fdone_d = 1'b1;
                end else begin
                    fch_d = fch_q + CW'(1);
                end
            end else begin
                fidx_d = fidx_q + AW'(1);
            end
        end else begin
            fidx_d = fidx_q;
        end

        // A stray sop realigns to bin 0; eop always closes the channel.
        if (col_s) begin
            res_addr_d = {och_q, idx_eff_s};
            res_data_d = {source_real, source_imag};
            if ((source_sop && (oidx_q != AW'(0))) || (source_eop && (idx_eff_s != LAST_IDX))) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
            if ((och_q == LAST_CH) && (idx_eff_s == LAST_IDX)) begin
                fin_d = 1'b1;
            end else begin
                fin_d = fin_q;
            end
            if (source_eop || (idx_eff_s == LAST_IDX)) begin
                oidx_d = AW'(0);
                och_d  = (och_q == LAST_CH) ? CW'(0) : och_q + CW'(1);
            end else begin
                oidx_d = idx_eff_s + AW'(1);
            end
        end else begin
            res_addr_d = res_addr_q;
        end

        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    state_d = ARM;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    fin_d   = 1'b0;
                    fch_d   = CW'(0);
                    fidx_d  = AW'(0);
                    fdone_d = 1'b0;
                    och_d   = CW'(0);
                    oidx_d  = AW'(0);
                end else begin
                    state_d = state_q;
                end
            end
            ARM: begin
                if (raw_ready && sink_ready) begin
                    state_d = FEED;
                end else begin
                    state_d = ARM;
                end
            end
            FEED: begin
                if (fdone_q && !pend_q && (occ_q == 2'd0)) begin
                    state_d = DRAIN;
                end else begin
                    state_d = FEED;
                end
            end
            DRAIN: begin
                if (fin_q) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register for the whole controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            fin_q      <= 1'b0;
            fch_q      <= '0;
            fidx_q     <= '0;
            fdone_q    <= 1'b0;
            och_q      <= '0;
            oidx_q     <= '0;
            pend_q     <= 1'b0;
            pend_sop_q <= 1'b0;
            pend_eop_q <= 1'b0;
            occ_q      <= 2'd0;
            s0_q       <= '0;
            s1_q       <= '0;
            res_wren_q <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            fin_q      <= fin_d;
            fch_q      <= fch_d;
            fidx_q     <= fidx_d;
            fdone_q    <= fdone_d;
            och_q      <= och_d;
            oidx_q     <= oidx_d;
            pend_q     <= pend_d;
            pend_sop_q <= pend_sop_d;
            pend_eop_q <= pend_eop_d;
            occ_q      <= occ_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            res_wren_q <= res_wren_d;
            res_addr_q <= res_addr_d;
            res_data_q <= res_data_d;
        end
    end

    assign raw_rdreq  = rdreq_s;
    assign raw_ch     = fch_q;
    assign raw_addr   = fidx_q;
    assign sink_valid = (occ_q != 2'd0);
    assign sink_sop   = sink_valid && s0_q[1];
    assign sink_eop   = sink_valid && s0_q[0];
    assign sink_real  = s0_q[SW-1:2];
    assign res_wren   = res_wren_q;
    assign res_addr   = res_addr_q;
    assign res_data   = res_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule
